// File: rtl/uart_rx_oversampled.sv
// rtl/uart_rx_oversampled.sv - 8N1 UART receiver driven by an external oversampling tick
module uart_rx_oversampled #(
  parameter int OVERSAMPLING = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  input  logic       tick,
  output logic       baud_en,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       framing_err,
  output logic       busy
);

  localparam int CNT_W = $clog2(OVERSAMPLING);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(OVERSAMPLING / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLING - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } state_e;

  state_e           state_q, state_d;
  logic             rx_meta_q, rx_s_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             dv_q, dv_d;
  logic             fe_q, fe_d;
  logic             baud_en_q, baud_en_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      dv_q      <= 1'b0;
      fe_q      <= 1'b0;
      baud_en_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      dv_q      <= dv_d;
      fe_q      <= fe_d;
      baud_en_q <= baud_en_d;
    end
  end

  // A tick coinciding with a transition is consumed by it: cnt is reloaded, not incremented.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    dv_d    = 1'b0;
    fe_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!rx_s_q) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (tick) begin
          if (cnt_q == CNT_MID) begin
            if (rx_s_q) begin
              state_d = IDLE;
            end else begin
              state_d = DATA;
              cnt_d   = '0;
              bit_d   = '0;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (cnt_q == CNT_LAST) begin
            shift_d = {rx_s_q, shift_q[7:1]};
            cnt_d   = '0;
            bit_d   = bit_q + 1'b1;
            if (bit_q == 3'd7) state_d = STOP;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (cnt_q == CNT_LAST) begin
            if (rx_s_q) begin
              data_d  = shift_q;
              dv_d    = 1'b1;
              state_d = IDLE;
            end else begin
              fe_d    = 1'b1;
              state_d = WAIT_IDLE;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      WAIT_IDLE: begin
        // Hold off until the line returns high so a break is not taken as a new start bit.
        if (rx_s_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    baud_en_d = (state_d == START) || (state_d == DATA) || (state_d == STOP);
  end

  assign baud_en     = baud_en_q;
  assign data        = data_q;
  assign data_valid  = dv_q;
  assign framing_err = fe_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// tb/tb_uart_rx_oversampled.sv - directed self-checking bench for uart_rx_oversampled
module tb_uart_rx_oversampled;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       tick = 1'b0;
  logic       baud_en;
  logic [7:0] data;
  logic       data_valid;
  logic       framing_err;
  logic       busy;

  int n_checks = 0;
  int n_pass = 0;

  int cyc = 0;
  int dv_cnt = 0;
  int fe_cnt = 0;
  int both_cnt = 0;
  int busy_cnt = 0;
  logic [7:0] dv_data [64];
  int         dv_time [64];

  logic tick_pause = 1'b0;
  int   tcnt = 0;

  uart_rx_oversampled #(.OVERSAMPLING(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx          (rx),
    .tick        (tick),
    .baud_en     (baud_en),
    .data        (data),
    .data_valid  (data_valid),
    .framing_err (framing_err),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Baud tick generator: one tick every 4 clk, phase restarted whenever baud_en is low.
  always @(negedge clk) begin
    if (!baud_en) begin
      tcnt = 0;
      tick = 1'b0;
    end else if (tick_pause) begin
      tick = 1'b0;
    end else begin
      tcnt = tcnt + 1;
      if (tcnt == 4) begin
        tick = 1'b1;
        tcnt = 0;
      end else begin
        tick = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (data_valid) begin
      if (dv_cnt < 64) begin
        dv_data[dv_cnt] = data;
        dv_time[dv_cnt] = cyc;
      end
      dv_cnt = dv_cnt + 1;
    end
    if (framing_err) fe_cnt = fe_cnt + 1;
    if (data_valid && framing_err) both_cnt = both_cnt + 1;
    if (busy) busy_cnt = busy_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks = n_checks + 1;
    if (observed === expected) n_pass = n_pass + 1;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
  endtask

  // Drives start, 8 data bits LSB first and stop; line bit ext_idx is stretched by ext_clks.
  task automatic send_frame(input logic [7:0] b, input logic stop_b, input int ext_idx, input int ext_clks);
    logic [9:0] line;
    line = {stop_b, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = line[i];
      repeat (32 + ((i == ext_idx) ? ext_clks : 0)) @(negedge clk);
    end
  endtask

  initial begin
    int dv0, fe0, bz0;
    logic [7:0] pb;

    repeat (5) @(negedge clk);
    check("rst_data", 32'(data), 32'h00);
    check("rst_dv", 32'(data_valid), 32'h0);
    check("rst_fe", 32'(framing_err), 32'h0);
    check("rst_baud_en", 32'(baud_en), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    dv0 = dv_cnt; fe0 = fe_cnt;
    send_frame(8'hA5, 1'b1, -1, 0);
    repeat (10) @(negedge clk);
    check("a5_dv_count", 32'(dv_cnt - dv0), 32'd1);
    check("a5_data", 32'(dv_data[dv0]), 32'hA5);
    check("a5_fe_count", 32'(fe_cnt - fe0), 32'd0);
    check("a5_idle", 32'(busy), 32'h0);

    dv0 = dv_cnt; fe0 = fe_cnt;
    send_frame(8'h00, 1'b1, -1, 0);
    send_frame(8'hFF, 1'b1, -1, 0);
    repeat (10) @(negedge clk);
    check("b2b_dv_count", 32'(dv_cnt - dv0), 32'd2);
    check("b2b_first", 32'(dv_data[dv0]), 32'h00);
    check("b2b_second", 32'(dv_data[dv0 + 1]), 32'hFF);
    check("b2b_spacing", 32'(dv_time[dv0 + 1] - dv_time[dv0]), 32'd320);
    check("b2b_fe_count", 32'(fe_cnt - fe0), 32'd0);

    dv0 = dv_cnt; fe0 = fe_cnt; bz0 = busy_cnt;
    rx = 1'b0;
    repeat (8) @(negedge clk);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch_busy_seen", 32'(busy_cnt > bz0), 32'h1);
    check("glitch_busy_end", 32'(busy), 32'h0);
    check("glitch_dv_count", 32'(dv_cnt - dv0), 32'd0);
    check("glitch_fe_count", 32'(fe_cnt - fe0), 32'd0);
    check("glitch_data", 32'(data), 32'hFF);

    dv0 = dv_cnt; fe0 = fe_cnt;
    send_frame(8'h3C, 1'b0, -1, 0);
    repeat (500) @(negedge clk);
    check("fe_count", 32'(fe_cnt - fe0), 32'd1);
    check("fe_busy_break", 32'(busy), 32'h1);
    check("fe_data", 32'(data), 32'hFF);
    rx = 1'b1;
    repeat (10) @(negedge clk);
    check("fe_busy_release", 32'(busy), 32'h0);
    repeat (300) @(negedge clk);
    check("fe_count_after", 32'(fe_cnt - fe0), 32'd1);
    check("fe_dv_count", 32'(dv_cnt - dv0), 32'd0);

    dv0 = dv_cnt; fe0 = fe_cnt;
    pb = 8'h77;
    rx = 1'b0;
    repeat (32) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = pb[i];
      repeat (32) @(negedge clk);
    end
    rx = pb[4];
    repeat (16) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_data", 32'(data), 32'h00);
    check("midrst_busy", 32'(busy), 32'h0);
    check("midrst_baud_en", 32'(baud_en), 32'h0);
    check("midrst_dv", 32'(data_valid), 32'h0);
    check("midrst_fe", 32'(framing_err), 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    rx = 1'b1;
    repeat (300) @(negedge clk);
    check("midrst_idle_after", 32'(busy), 32'h0);
    check("midrst_no_pulse", 32'((dv_cnt - dv0) + (fe_cnt - fe0)), 32'd0);
    send_frame(8'h5A, 1'b1, -1, 0);
    repeat (10) @(negedge clk);
    check("post_rst_dv_count", 32'(dv_cnt - dv0), 32'd1);
    check("post_rst_data", 32'(data), 32'h5A);

    dv0 = dv_cnt; fe0 = fe_cnt;
    fork
      send_frame(8'hC3, 1'b1, 4, 200);
      begin
        repeat (136) @(posedge clk);
        #1 tick_pause = 1'b1;
        repeat (100) @(posedge clk);
        #1;
        check("pause_busy", 32'(busy), 32'h1);
        check("pause_baud_en", 32'(baud_en), 32'h1);
        repeat (100) @(posedge clk);
        #1 tick_pause = 1'b0;
      end
    join
    repeat (10) @(negedge clk);
    check("pause_dv_count", 32'(dv_cnt - dv0), 32'd1);
    check("pause_data", 32'(data), 32'hC3);
    check("pause_fe_count", 32'(fe_cnt - fe0), 32'd0);

    check("dv_fe_overlap", 32'(both_cnt), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
